// File: rtl/midi_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : midi_key_encoder
// Brief    : Debounces NUM_KEYS keys and streams MIDI Note-On/Off messages
//            bytewise over a valid/ready interface through an event FIFO.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module midi_key_encoder #(
    parameter int NUM_KEYS   = 10,
    parameter int DB_CYCLES  = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int BASE_NOTE  = 60,
    parameter int CHANNEL    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           keys_raw,
    input  logic [4:0]                    pitchshift,
    input  logic [6:0]                    velocity,
    input  logic                          enable,
    output logic [NUM_KEYS-1:0]           keys_db,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W  = $clog2(DB_CYCLES);
    localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]       CH = 4'(CHANNEL);

    // Reset: asynchronous assert, release synchronised to clk.
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int_n = rst_pipe[1];

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keys_raw;
            sync2 <= sync1;
        end
    end

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_debounce
            logic [CNT_W-1:0] cnt;
            logic             db;

            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    cnt <= '0;
                    db  <= 1'b0;
                end else if (sync2[k] == db) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt <= '0;
                    db  <= ~db;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign keys_db[k] = db;
        end
    endgenerate

    logic [NUM_KEYS-1:0] keys_db_q;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] fall;

    assign rise = keys_db & ~keys_db_q;
    assign fall = ~keys_db & keys_db_q;

    logic [NUM_KEYS-1:0] on_pend;
    logic [NUM_KEYS-1:0] off_pend;
    logic [NUM_KEYS-1:0] sounding;
    logic [6:0]          note_lat [NUM_KEYS];

    // Scanner: lowest-index Off first, then lowest-index On.
    logic             off_found;
    logic             on_found;
    logic [IDX_W-1:0] off_idx;
    logic [IDX_W-1:0] on_idx;

    always_comb begin
        off_found = 1'b0;
        on_found  = 1'b0;
        off_idx   = '0;
        on_idx    = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (off_pend[i]) begin
                off_found = 1'b1;
                off_idx   = IDX_W'(i);
            end
            if (on_pend[i]) begin
                on_found = 1'b1;
                on_idx   = IDX_W'(i);
            end
        end
    end

    logic [8:0] note_sum;
    logic [6:0] note_on;

    assign note_sum = 9'(BASE_NOTE) + 9'(on_idx) + {{4{pitchshift[4]}}, pitchshift};
    assign note_on  = note_sum[8] ? 7'd0 : (note_sum[7] ? 7'd127 : note_sum[6:0]);

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [7:0]       push_data;
    logic [7:0]       rd_data;

    assign fifo_full  = (fifo_level == LVL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = (off_found | on_found) & ~fifo_full;
    assign push_data  = off_found ? {1'b0, note_lat[off_idx]} : {1'b1, note_on};

    // The scanner's effect is applied before the edges of the same cycle, so a
    // release coinciding with its own Note-On push still queues the Note-Off.
    logic [NUM_KEYS-1:0] on_n;
    logic [NUM_KEYS-1:0] off_n;
    logic [NUM_KEYS-1:0] snd_n;

    always_comb begin
        on_n  = on_pend;
        off_n = off_pend;
        snd_n = sounding;
        if (push) begin
            if (off_found) begin
                off_n[off_idx] = 1'b0;
                snd_n[off_idx] = 1'b0;
            end else begin
                on_n[on_idx]  = 1'b0;
                snd_n[on_idx] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (rise[i] && enable) begin
                on_n[i] = 1'b1;
            end
            if (fall[i]) begin
                if (on_n[i]) begin
                    on_n[i] = 1'b0;
                end else if (snd_n[i]) begin
                    off_n[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            keys_db_q <= '0;
            on_pend   <= '0;
            off_pend  <= '0;
            sounding  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                note_lat[i] <= 7'd0;
            end
        end else begin
            keys_db_q <= keys_db;
            on_pend   <= on_n;
            off_pend  <= off_n;
            sounding  <= snd_n;
            if (push && !off_found) begin
                note_lat[on_idx] <= note_on;
            end
        end
    end

    logic [7:0]      mem [FIFO_DEPTH];
    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[ADDR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign fifo_level = wptr - rptr;
    assign rd_data    = mem[rptr[ADDR_W-1:0]];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STATUS = 2'd1,
        S_NOTE   = 2'd2,
        S_VEL    = 2'd3
    } ser_state_t;

    ser_state_t state;
    logic       ev_on;
    logic [6:0] ev_note;
    logic [6:0] ev_vel;

    assign pop = (state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= S_IDLE;
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            ev_on   <= 1'b0;
            ev_note <= 7'd0;
            ev_vel  <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        ev_on   <= rd_data[7];
                        ev_note <= rd_data[6:0];
                        ev_vel  <= (velocity == 7'd0) ? 7'd1 : velocity;
                        m_data  <= {(rd_data[7] ? 4'h9 : 4'h8), CH};
                        m_valid <= 1'b1;
                        state   <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    if (m_valid && m_ready) begin
                        m_data <= {1'b0, ev_note};
                        state  <= S_NOTE;
                    end
                end
                S_NOTE: begin
                    if (m_valid && m_ready) begin
                        m_data <= ev_on ? {1'b0, ev_vel} : 8'h40;
                        state  <= S_VEL;
                    end
                end
                S_VEL: begin
                    if (m_valid && m_ready) begin
                        m_data  <= 8'h00;
                        m_valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_midi_key_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_key_encoder
// Brief    : Directed self-checking bench for midi_key_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_key_encoder;

    logic       clk;
    logic       rst_n;
    logic [9:0] keys_raw;
    logic [4:0] pitchshift;
    logic [6:0] velocity;
    logic       enable;
    logic [9:0] keys_db;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] fifo_level;

    logic [9:0] keys_raw2;
    logic [4:0] pitchshift2;
    logic [6:0] velocity2;
    logic [9:0] keys_db2;
    logic [7:0] m_data2;
    logic       m_valid2;
    logic       m_ready2;
    logic [3:0] fifo_level2;

    int checks = 0;
    int errors = 0;

    logic [7:0] q  [$];
    logic [7:0] q2 [$];

    midi_key_encoder dut (
        .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .pitchshift(pitchshift),
        .velocity(velocity), .enable(enable), .keys_db(keys_db), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level)
    );

    midi_key_encoder #(.DB_CYCLES(4), .BASE_NOTE(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw2), .pitchshift(pitchshift2),
        .velocity(velocity2), .enable(1'b1), .keys_db(keys_db2), .m_data(m_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .fifo_level(fifo_level2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) q.push_back(m_data);
        if (m_valid2 === 1'b1 && m_ready2 === 1'b1) q2.push_back(m_data2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input int n, input int budget);
        int c = 0;
        while (q.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", m_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (keys_db !== 10'h000) begin errors++; $display("FAIL reset_keys_db got %03h want 000", keys_db); end
    endtask

    task automatic test_press_latency();
        logic [7:0] exp [3];
        logic [7:0] got;
        exp = '{8'h90, 8'h3C, 8'h64};
        q.delete();
        keys_raw[0] = 1'b1;
        repeat (257) tick();
        checks++; if (keys_db[0] !== 1'b0) begin errors++; $display("FAIL db_early got %b want 0", keys_db[0]); end
        tick();
        checks++; if (keys_db[0] !== 1'b1) begin errors++; $display("FAIL db_rise got %b want 1", keys_db[0]); end
        repeat (2) tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", m_valid); end
        tick();
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h90) begin
            errors++; $display("FAIL lat_status got v=%b d=%02h want v=1 d=90", m_valid, m_data);
        end
        wait_q(3, 20);
        for (int i = 0; i < 3; i++) begin
            got = 8'hxx;
            if (q.size() > 0) got = q.pop_front();
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL press_on byte%0d got %02h want %02h", i, got, exp[i]); end
        end
    endtask

    task automatic test_latched_off();
        logic [7:0] exp [3];
        logic [7:0] got;
        exp = '{8'h80, 8'h3C, 8'h40};
        q.delete();
        pitchshift = 5'd2;
        repeat (10) tick();
        keys_raw[0] = 1'b0;
        wait_q(3, 400);
        for (int i = 0; i < 3; i++) begin
            got = 8'hxx;
            if (q.size() > 0) got = q.pop_front();
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL latched_off byte%0d got %02h want %02h", i, got, exp[i]); end
        end
        pitchshift = 5'd0;
    endtask

    task automatic test_bounce();
        logic [7:0] exp [6];
        logic [7:0] got;
        exp = '{8'h90, 8'h3F, 8'h64, 8'h80, 8'h3F, 8'h40};
        q.delete();
        keys_raw[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat (100) tick();
            keys_raw[3] = ~keys_raw[3];
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL bounce_quiet got %0d bytes want 0", q.size()); end
        wait_q(3, 600);
        repeat (100) tick();
        checks++; if (q.size() != 3) begin errors++; $display("FAIL bounce_count got %0d bytes want 3", q.size()); end
        keys_raw[3] = 1'b0;
        wait_q(6, 600);
        for (int i = 0; i < 6; i++) begin
            got = 8'hxx;
            if (q.size() > 0) got = q.pop_front();
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL bounce byte%0d got %02h want %02h", i, got, exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic [7:0] want;
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        int         bad;
        int         c;
        q.delete();
        m_ready  = 1'b0;
        keys_raw = 10'h3FF;
        repeat (270) tick();
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL burst_full got %0d want 8", fifo_level); end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== 8'h90 || fifo_level !== 4'd8) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_hold got %0d bad cycles want 0", bad); end
        bad = 0;
        c = 0;
        while (q.size() < 30 && c < 3000) begin
            pv = m_valid;
            pd = m_data;
            pr = c[0];
            m_ready = pr;
            tick();
            if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) bad++;
            c++;
        end
        m_ready = 1'b1;
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable got %0d bad cycles want 0", bad); end
        for (int k = 0; k < 10; k++) begin
            for (int b = 0; b < 3; b++) begin
                want = (b == 0) ? 8'h90 : ((b == 1) ? 8'(60 + k) : 8'h64);
                got = 8'hxx;
                if (q.size() > 0) got = q.pop_front();
                checks++; if (got !== want) begin errors++; $display("FAIL burst_on key%0d byte%0d got %02h want %02h", k, b, got, want); end
            end
        end
        repeat (5) tick();
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL burst_drained got %0d want 0", fifo_level); end
        keys_raw = 10'h000;
        wait_q(30, 2000);
        for (int k = 0; k < 10; k++) begin
            for (int b = 0; b < 3; b++) begin
                want = (b == 0) ? 8'h80 : ((b == 1) ? 8'(60 + k) : 8'h40);
                got = 8'hxx;
                if (q.size() > 0) got = q.pop_front();
                checks++; if (got !== want) begin errors++; $display("FAIL burst_off key%0d byte%0d got %02h want %02h", k, b, got, want); end
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] exp [6];
        logic [7:0] got;
        exp = '{8'h90, 8'h41, 8'h64, 8'h80, 8'h41, 8'h40};
        q.delete();
        keys_raw[5] = 1'b1;
        wait_q(3, 400);
        enable = 1'b0;
        keys_raw[5] = 1'b0;
        wait_q(6, 400);
        for (int i = 0; i < 6; i++) begin
            got = 8'hxx;
            if (q.size() > 0) got = q.pop_front();
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL enable_off byte%0d got %02h want %02h", i, got, exp[i]); end
        end
        keys_raw[6] = 1'b1;
        repeat (400) tick();
        checks++; if (keys_db[6] !== 1'b1) begin errors++; $display("FAIL disabled_db got %b want 1", keys_db[6]); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL disabled_press got %0d bytes want 0", q.size()); end
        keys_raw[6] = 1'b0;
        repeat (400) tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL disabled_release got %0d bytes want 0", q.size()); end
        enable = 1'b1;
    endtask

    task automatic test_clamp();
        logic [7:0] exp [3];
        logic [7:0] got;
        int         c;
        exp = '{8'h90, 8'h00, 8'h01};
        q2.delete();
        pitchshift2 = 5'b10000;
        velocity2   = 7'd0;
        keys_raw2[0] = 1'b1;
        c = 0;
        while (q2.size() < 3 && c < 100) begin
            tick();
            c++;
        end
        for (int i = 0; i < 3; i++) begin
            got = 8'hxx;
            if (q2.size() > 0) got = q2.pop_front();
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL clamp byte%0d got %02h want %02h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        q.delete();
        m_ready = 1'b0;
        keys_raw[1] = 1'b1;
        keys_raw[2] = 1'b1;
        c = 0;
        while (m_valid !== 1'b1 && c < 400) begin
            tick();
            c++;
        end
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL mid_level got %0d want 1", fifo_level); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h3D) begin
            errors++; $display("FAIL mid_note got v=%b d=%02h want v=1 d=3D", m_valid, m_data);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", m_valid); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL async_level got %0d want 0", fifo_level); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL async_data got %02h want 00", m_data); end
        keys_raw = 10'h000;
        m_ready  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        q.delete();
        repeat (300) tick();
        checks++; if (q.size() != 0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset got %0d bytes v=%b want 0 bytes v=0", q.size(), m_valid);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        keys_raw    = '0;
        pitchshift  = 5'd0;
        velocity    = 7'd100;
        enable      = 1'b1;
        m_ready     = 1'b1;
        keys_raw2   = '0;
        pitchshift2 = 5'd0;
        velocity2   = 7'd0;
        m_ready2    = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        test_reset();
        test_press_latency();
        test_latched_off();
        test_bounce();
        test_back_to_back();
        test_enable();
        test_clamp();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/midi_key_encoder.md
Name: midi_key_encoder

Overview:
- Parametrised successor to the fixed 10-key debounce/note front end.
- Debounces NUM_KEYS raw key inputs and detects press/release edges.
- Converts each edge into a 3-byte MIDI Note-On/Note-Off message with pitch shift and velocity.
- Queues messages in an event FIFO and streams them bytewise over a valid/ready interface to the UART transmitter.

Parameters:
- NUM_KEYS, 10: number of key inputs.
- DB_CYCLES, 256: consecutive cycles a raw level must hold before it is accepted; must be at least 2.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2.
- BASE_NOTE, 60: MIDI note for key 0 at zero shift.
- CHANNEL, 0: MIDI channel, range 0..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- keys_raw  in  NUM_KEYS  raw key levels; 1 = pressed; asynchronous to clk, synchronised internally with 2 flops.
- pitchshift  in  5  two's-complement semitone offset, -16..+15.
- velocity  in  7  Note-On velocity.
- enable  in  1  1 = accept new presses.
- keys_db  out  NUM_KEYS  debounced key levels.
- m_data  out  8  MIDI byte.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the byte.
- fifo_level  out  clog2(FIFO_DEPTH)+1  event FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert inside the block) clears:
  - synchronisers, debounce counters, keys_db and per-key sounding/pending/latched-note registers;
  - FIFO (fifo_level=0);
  - serialiser to IDLE, with m_valid=0 and m_data=0x00.
- Debounce, per key:
  - If the synchronised level equals keys_db, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DB_CYCLES-1, keys_db toggles and the counter clears.
  - Net effect: keys_db changes DB_CYCLES cycles after a stable raw change (plus 2 synchroniser cycles).
- Edge to pending, registered on the cycle after the keys_db change:
  - 0->1 with enable=1: set on_pend.
  - 0->1 with enable=0: ignored; the key is not sounding.
  - 1->0 while on_pend is set (not yet queued): clear on_pend; no events are sent for that press.
  - 1->0 while the key is sounding: set off_pend.
- Scanner, one event per cycle, FIFO not full:
  - Selects the lowest-index key with off_pend, else the lowest-index key with on_pend.
  - Off always has priority over on, including for the same key.
  - It clears that pending bit and writes {type, note} to the FIFO.
- Note computation for a Note-On:
  - note = BASE_NOTE + index + sign-extended pitchshift, computed in 9-bit signed arithmetic.
  - The result is clamped to 0..127.
  - The note is latched per key, and sounding is set.
- Note-Off:
  - Uses the latched note, so a pitchshift change while held never strands a note.
  - Clears sounding.
- FIFO full:
  - Pending bits persist and no event is lost.
  - Debounce continues; scanning resumes when space frees.
- enable=0 blocks only new presses. Note-Offs for sounding keys are still emitted.
- Serialiser FSM: IDLE -> STATUS -> NOTE -> VEL -> IDLE.
  - IDLE: when the FIFO is non-empty, pop and go to STATUS with m_valid=1 the next cycle.
  - STATUS byte: 0x90|CHANNEL for On, 0x80|CHANNEL for Off.
  - NOTE byte: the note.
  - VEL byte for On: velocity sampled at pop; a value of 0 is sent as 1.
  - VEL byte for Off: 0x40.
  - Each state advances only on m_valid & m_ready.
  - m_data and m_valid are held stable while m_valid & !m_ready.
  - After VEL is accepted, go to IDLE; m_valid=0 for at least one cycle between messages.
- Latency: with the FIFO empty and the serialiser idle, m_valid (STATUS) rises 3 cycles after keys_db changes (pending, push, pop).
- A simultaneous FIFO push and pop in the same cycle leaves fifo_level unchanged.
- Reset mid-message: m_valid drops immediately and the partial message is abandoned.

Test Plan:
- Key 0 raw 0->1 held, pitchshift=0, velocity=100, m_ready=1 -> keys_db[0] rises after 2+256 cycles; bytes 0x90, 0x3C, 0x64.
- Key 0 released with pitchshift changed to +2 while held -> bytes 0x80, 0x3C, 0x40 (latched note, not 0x3E).
- Key 3 bouncing every 100 cycles for 2000 cycles, then stable high -> exactly one Note-On, note 0x3F.
- All 10 keys pressed in the same cycle, m_ready=0 for 200 cycles -> fifo_level saturates at 8 and holds; after m_ready=1, 10 Note-Ons in index order; stall never alters m_data.
- pitchshift=-16 with BASE_NOTE=5 on key 0 -> note clamps to 0x00; velocity=0 -> VEL byte 0x01.
- Key held, then enable=0, then key released -> Note-Off still sent; a new press while enable=0 produces no bytes. Reset asserted during the NOTE byte -> m_valid=0 asynchronously and FIFO empty.
